// File: rtl/bennett_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bennett_pkg
// Purpose : Shared Bennett clock-bus types, defaults and thermometer helper.
// Rev     : 1.0  initial release
// ============================================================================
package bennett_pkg;

    localparam int PHASES_DEF = 4;
    localparam int MAX_PHASES = 32;
    localparam int MAX_K_W    = 6;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RISE  = 3'd1,
        TOP   = 3'd2,
        FALL  = 3'd3,
        ERROR = 3'd4
    } phase_state_e;

    typedef struct packed {
        logic               valid;
        logic [MAX_K_W-1:0] k;
    } thermo_t;

    // Valid only when the set bits form a contiguous run starting at bit 0.
    function automatic thermo_t is_thermo(input logic [MAX_PHASES-1:0] vec);
        thermo_t               res;
        logic [MAX_PHASES-1:0] mask;
        res.k = '0;
        for (int i = 0; i < MAX_PHASES; i++) begin
            res.k = res.k + MAX_K_W'(vec[i]);
        end
        for (int i = 0; i < MAX_PHASES; i++) begin
            mask[i] = (MAX_K_W'(i) < res.k);
        end
        res.valid = (vec == mask);
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bennett_thermo_check.sv
`default_nettype none
// ============================================================================
// Module  : bennett_thermo_check
// Purpose : Combinational popcount and thermometer-code validity of a phase vector.
// Rev     : 1.0  initial release
// ============================================================================
module bennett_thermo_check
    import bennett_pkg::*;
#(
    parameter int PHASES = PHASES_DEF
) (
    input  logic [PHASES-1:0]           vec,
    output logic                        valid,
    output logic [$clog2(PHASES+1)-1:0] k
);

    localparam int LVL_W = $clog2(PHASES + 1);

    thermo_t w_res;

    always_comb begin
        w_res = is_thermo(MAX_PHASES'(vec));
        valid = w_res.valid;
        k     = LVL_W'(w_res.k);
    end

endmodule
`default_nettype wire

// File: rtl/bennett_phase_decoder.sv
`default_nettype none
// ============================================================================
// Module  : bennett_phase_decoder
// Purpose : Tracks the Bennett rise/top/fall/idle phase sequence and emits strobes.
// Rev     : 1.0  initial release
// ============================================================================
module bennett_phase_decoder
    import bennett_pkg::*;
#(
    parameter int PHASES = PHASES_DEF,
    parameter int CNT_W  = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [PHASES-1:0]           clkp,
    input  logic                        instFlag,
    input  logic                        err_clr,
    output logic [$clog2(PHASES+1)-1:0] level,
    output logic                        dir,
    output logic [PHASES-1:0]           stage_en,
    output logic [PHASES-1:0]           stage_rel,
    output logic                        cycle_done,
    output logic [CNT_W-1:0]            cycle_count,
    output logic                        err,
    output logic                        locked
);

    localparam int               LVL_W    = $clog2(PHASES + 1);
    localparam logic [LVL_W-1:0] C_ONE    = LVL_W'(1);
    localparam logic [LVL_W-1:0] C_TOP    = LVL_W'(PHASES);
    localparam logic [LVL_W-1:0] C_TOP_M1 = LVL_W'(PHASES - 1);

    logic [PHASES-1:0] r_clkp_q;
    logic              r_if_q;
    phase_state_e      r_state, w_nxt_state;
    logic              r_synced;
    logic [LVL_W-1:0]  r_level, w_nxt_level;
    logic              r_dir, w_nxt_dir;
    logic [PHASES-1:0] r_stage_en, r_stage_rel, w_nxt_en, w_nxt_rel;
    logic              r_done, w_nxt_done;
    logic [CNT_W-1:0]  r_count, w_nxt_count;
    logic              r_err, r_locked;
    logic              w_err_det;
    logic              w_valid;
    logic [LVL_W-1:0]  w_k;
    logic              w_all_low, w_boundary;

    bennett_thermo_check #(.PHASES(PHASES)) u_thermo (
        .vec   (r_clkp_q),
        .valid (w_valid),
        .k     (w_k)
    );

    assign w_all_low  = (r_clkp_q == '0);
    assign w_boundary = w_all_low & r_if_q;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_level = r_level;
        w_nxt_dir   = r_dir;
        w_nxt_en    = '0;
        w_nxt_rel   = '0;
        w_nxt_done  = 1'b0;
        w_nxt_count = r_count;
        w_err_det   = 1'b0;
        case (r_state)
            IDLE: begin
                // Stale levels right after reset are tolerated until the first boundary.
                if (!w_valid) begin
                    w_err_det = 1'b1;
                end else if (w_boundary) begin
                    w_nxt_state = RISE;
                    w_nxt_dir   = 1'b1;
                end else if (!w_all_low && r_synced) begin
                    w_err_det = 1'b1;
                end
            end
            RISE: begin
                if (!w_valid) begin
                    w_err_det = 1'b1;
                end else if (w_k == r_level) begin
                    w_nxt_state = RISE;
                end else if (w_k == r_level + C_ONE) begin
                    w_nxt_level = w_k;
                    w_nxt_en    = PHASES'(1) << (w_k - C_ONE);
                    if (w_k == C_TOP) begin
                        w_nxt_state = TOP;
                    end
                end else begin
                    w_err_det = 1'b1;
                end
            end
            TOP: begin
                if (w_valid && w_k == C_TOP) begin
                    w_nxt_state = TOP;
                end else if (w_valid && w_k == C_TOP_M1) begin
                    w_nxt_state = FALL;
                    w_nxt_dir   = 1'b0;
                    w_nxt_level = C_TOP_M1;
                    w_nxt_rel   = PHASES'(1) << C_TOP_M1;
                end else begin
                    w_err_det = 1'b1;
                end
            end
            FALL: begin
                if (!w_valid) begin
                    w_err_det = 1'b1;
                end else if (w_k == r_level) begin
                    w_nxt_state = FALL;
                end else if (w_k == r_level - C_ONE) begin
                    w_nxt_level = w_k;
                    w_nxt_rel   = PHASES'(1) << w_k;
                    if (w_k == '0) begin
                        w_nxt_state = IDLE;
                        w_nxt_done  = 1'b1;
                        w_nxt_count = r_count + CNT_W'(1);
                    end
                end else begin
                    w_err_det = 1'b1;
                end
            end
            ERROR: begin
                w_nxt_level = '0;
                w_nxt_dir   = 1'b0;
                if (w_boundary) begin
                    w_nxt_state = RISE;
                    w_nxt_dir   = 1'b1;
                end
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
        if (w_err_det) begin
            w_nxt_state = ERROR;
            w_nxt_level = '0;
            w_nxt_dir   = 1'b0;
            w_nxt_en    = '0;
            w_nxt_rel   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clkp_q    <= '0;
            r_if_q      <= 1'b0;
            r_state     <= IDLE;
            r_synced    <= 1'b0;
            r_level     <= '0;
            r_dir       <= 1'b0;
            r_stage_en  <= '0;
            r_stage_rel <= '0;
            r_done      <= 1'b0;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_clkp_q    <= clkp;
            r_if_q      <= instFlag;
            r_state     <= w_nxt_state;
            r_level     <= w_nxt_level;
            r_dir       <= w_nxt_dir;
            r_stage_en  <= w_nxt_en;
            r_stage_rel <= w_nxt_rel;
            r_done      <= w_nxt_done;
            r_count     <= w_nxt_count;
            r_err       <= w_err_det | (r_err & ~err_clr);
            r_locked    <= (w_nxt_state == RISE) || (w_nxt_state == TOP) ||
                           (w_nxt_state == FALL);
            if (w_nxt_state == RISE) begin
                r_synced <= 1'b1;
            end
        end
    end

    assign level       = r_level;
    assign dir         = r_dir;
    assign stage_en    = r_stage_en;
    assign stage_rel   = r_stage_rel;
    assign cycle_done  = r_done;
    assign cycle_count = r_count;
    assign err         = r_err;
    assign locked      = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_bennett_phase_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_bennett_phase_decoder
// Purpose : Directed scoreboard bench for bennett_phase_decoder (PHASES=4).
// Rev     : 1.0  initial release
// ============================================================================
module tb_bennett_phase_decoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  clkp = 4'b0;
    logic        instFlag = 1'b0;
    logic        err_clr = 1'b0;

    logic [2:0]  level;
    logic        dir, cycle_done, err, locked;
    logic [3:0]  stage_en, stage_rel;
    logic [15:0] cycle_count;

    // Narrow-counter instance sharing all inputs, used to observe wrap-around.
    logic [2:0]  n_level;
    logic        n_dir, n_cycle_done, n_err, n_locked;
    logic [3:0]  n_stage_en, n_stage_rel;
    logic [2:0]  n_cycle_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  rel;
        logic        done;
        logic [2:0]  lvl;
        logic        dir;
        logic        lock;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];

    logic [3:0] tc_code [10] = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'h7, 4'h3, 4'h1, 4'h0};
    logic [3:0] tc_en   [10] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] tc_rel  [10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h4, 4'h2, 4'h1};
    logic [2:0] tc_lvl  [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    logic       tc_dir  [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       tc_lock [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    bennett_phase_decoder #(.PHASES(4), .CNT_W(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clkp        (clkp),
        .instFlag    (instFlag),
        .err_clr     (err_clr),
        .level       (level),
        .dir         (dir),
        .stage_en    (stage_en),
        .stage_rel   (stage_rel),
        .cycle_done  (cycle_done),
        .cycle_count (cycle_count),
        .err         (err),
        .locked      (locked)
    );

    bennett_phase_decoder #(.PHASES(4), .CNT_W(3)) dut_n (
        .clk         (clk),
        .reset_n     (reset_n),
        .clkp        (clkp),
        .instFlag    (instFlag),
        .err_clr     (err_clr),
        .level       (n_level),
        .dir         (n_dir),
        .stage_en    (n_stage_en),
        .stage_rel   (n_stage_rel),
        .cycle_done  (n_cycle_done),
        .cycle_count (n_cycle_count),
        .err         (n_err),
        .locked      (n_locked)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one input step; outputs for a step appear one step later, so the
    // scoreboard compares the previous entry. err is checked at every edge.
    task automatic step(input logic [3:0] c, input logic f, input logic clr,
                        input logic [3:0] en, input logic [3:0] rel, input logic done,
                        input logic [2:0] lvl, input logic d, input logic lk,
                        input logic [15:0] cnt, input logic e_err);
        exp_t x;
        @(negedge clk);
        clkp     = c;
        instFlag = f;
        err_clr  = clr;
        x.en = en; x.rel = rel; x.done = done; x.lvl = lvl;
        x.dir = d; x.lock = lk; x.cnt = cnt;
        q.push_back(x);
        @(posedge clk);
        #1;
        chk("err", err, e_err);
        if (q.size() >= 2) begin
            x = q.pop_front();
            chk("stage_en", stage_en, x.en);
            chk("stage_rel", stage_rel, x.rel);
            chk("cycle_done", cycle_done, x.done);
            chk("level", level, x.lvl);
            chk("dir", dir, x.dir);
            chk("locked", locked, x.lock);
            chk("cycle_count", cycle_count, x.cnt);
            chk("narrow_done", n_cycle_done, x.done);
            chk("narrow_count", n_cycle_count, x.cnt[2:0]);
        end
    endtask

    task automatic run_cycle(input int hold, input logic [15:0] c0, input logic e);
        logic [15:0] cn;
        for (int i = 0; i < 10; i++) begin
            cn = (i == 9) ? c0 + 16'd1 : c0;
            step(tc_code[i], i == 0, 1'b0, tc_en[i], tc_rel[i], i == 9,
                 tc_lvl[i], tc_dir[i], tc_lock[i], cn, e);
            if (hold != 0) begin
                step(tc_code[i], i == 0, 1'b0, 4'h0, 4'h0, 1'b0,
                     tc_lvl[i], tc_dir[i], tc_lock[i], cn, e);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_dir"}, dir, 0);
        chk({tag, "_stage_en"}, stage_en, 0);
        chk({tag, "_stage_rel"}, stage_rel, 0);
        chk({tag, "_done"}, cycle_done, 0);
        chk({tag, "_count"}, cycle_count, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_locked"}, locked, 0);
    endtask

    initial begin
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Clean cycle, then the same cycle with every step held once.
        run_cycle(0, 16'd0, 1'b0);
        run_cycle(1, 16'd1, 1'b0);

        // Non-thermometer code mid-rise, then resync and clear.
        step(4'h0, 1, 0, 4'h0, 4'h0, 0, 3'd0, 1, 1, 16'd2, 0);
        step(4'h1, 0, 0, 4'h1, 4'h0, 0, 3'd1, 1, 1, 16'd2, 0);
        step(4'h5, 0, 0, 4'h0, 4'h0, 0, 3'd0, 0, 0, 16'd2, 0);
        step(4'h7, 0, 0, 4'h0, 4'h0, 0, 3'd0, 0, 0, 16'd2, 1);
        step(4'h3, 0, 0, 4'h0, 4'h0, 0, 3'd0, 0, 0, 16'd2, 1);
        step(4'h0, 0, 0, 4'h0, 4'h0, 0, 3'd0, 0, 0, 16'd2, 1);
        run_cycle(0, 16'd2, 1'b1);
        step(4'h0, 0, 1, 4'h0, 4'h0, 0, 3'd0, 0, 0, 16'd3, 0);

        // Skipped step; err_clr in the detection cycle loses to the new error.
        step(4'h0, 1, 0, 4'h0, 4'h0, 0, 3'd0, 1, 1, 16'd3, 0);
        step(4'h1, 0, 0, 4'h1, 4'h0, 0, 3'd1, 1, 1, 16'd3, 0);
        step(4'h7, 0, 1, 4'h0, 4'h0, 0, 3'd0, 0, 0, 16'd3, 0);
        step(4'h0, 0, 1, 4'h0, 4'h0, 0, 3'd0, 0, 0, 16'd3, 1);
        step(4'h0, 0, 1, 4'h0, 4'h0, 0, 3'd0, 0, 0, 16'd3, 0);

        // Reach FALL at level 3, then reset asynchronously.
        step(4'h0, 1, 0, 4'h0, 4'h0, 0, 3'd0, 1, 1, 16'd3, 0);
        step(4'h1, 0, 0, 4'h1, 4'h0, 0, 3'd1, 1, 1, 16'd3, 0);
        step(4'h3, 0, 0, 4'h2, 4'h0, 0, 3'd2, 1, 1, 16'd3, 0);
        step(4'h7, 0, 0, 4'h4, 4'h0, 0, 3'd3, 1, 1, 16'd3, 0);
        step(4'hF, 0, 0, 4'h8, 4'h0, 0, 3'd4, 1, 1, 16'd3, 0);
        step(4'h7, 0, 0, 4'h0, 4'h8, 0, 3'd3, 0, 1, 16'd3, 0);
        step(4'h7, 0, 0, 4'h0, 4'h0, 0, 3'd3, 0, 1, 16'd3, 0);
        @(negedge clk);
        reset_n  = 1'b0;
        clkp     = 4'h3;
        instFlag = 1'b0;
        err_clr  = 1'b0;
        #1;
        chk_all_zero("async_reset");
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step(4'h3, 0, 0, 4'h0, 4'h0, 0, 3'd0, 0, 0, 16'd0, 0);
        step(4'h3, 0, 0, 4'h0, 4'h0, 0, 3'd0, 0, 0, 16'd0, 0);
        step(4'h1, 0, 0, 4'h0, 4'h0, 0, 3'd0, 0, 0, 16'd0, 0);
        step(4'h0, 0, 0, 4'h0, 4'h0, 0, 3'd0, 0, 0, 16'd0, 0);
        run_cycle(0, 16'd0, 1'b0);

        // Eight more cycles: the 3-bit counter wraps 7 -> 0 with a done pulse.
        for (int c = 1; c <= 8; c++) begin
            run_cycle(0, 16'(c), 1'b0);
        end
        step(4'h0, 0, 0, 4'h0, 4'h0, 0, 3'd0, 0, 0, 16'd9, 0);
        step(4'h0, 0, 0, 4'h0, 4'h0, 0, 3'd0, 0, 0, 16'd9, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bennett_phase_decoder.md
Name: bennett_phase_decoder

Overview:
Receiver-side tracker for the multi-phase Bennett clock bus. It samples the PHASES-wide phase vector and instFlag, and follows the rise/top/fall/idle sequence. It emits per-stage compute and uncompute strobes, the current level and a cycle counter to the reversible datapath stages. It flags any sequence that breaks the Bennett protocol and resynchronises on the next instruction boundary.

Parameters:
PHASES, 4, number of clock phases (>=2).
CNT_W, 16, width of completed-cycle counter.

Ports:
clk  in  1  system clock, same domain as the phase generator.
reset_n  in  1  asynchronous active-low reset.
clkp  in  PHASES  phase levels from the generator; a ramping phase may read as either its old or its new level.
instFlag  in  1  generator instruction-boundary flag (high while all phases are low).
err_clr  in  1  clears sticky err.
level  out  $clog2(PHASES+1)  number of phases currently high (tracked).
dir  out  1  1 = compute (rising or top), 0 = uncompute (falling or idle).
stage_en  out  PHASES  one-cycle pulse: bit i when phase i completes its rise.
stage_rel  out  PHASES  one-cycle pulse: bit i when phase i completes its fall.
cycle_done  out  1  one-cycle pulse when a full rise/fall returns to all-low.
cycle_count  out  CNT_W  completed cycles, wraps modulo 2^CNT_W.
err  out  1  sticky protocol error.
locked  out  1  high in RISE/TOP/FALL.

Behaviour:
- Reset (async, reset_n=0): all outputs 0, FSM=IDLE, sample registers 0.
- Input stage: clkp and instFlag are registered once (clkp_q, if_q). No synchroniser; same clock domain.
- k = popcount(clkp_q). The code is valid only if clkp_q == (1<<k)-1 (thermometer, phase 0 lowest).
- All outputs are registered. The FSM acts on clkp_q, so outputs reflect an input change 2 clk edges after it.
- FSM states: IDLE, RISE, TOP, FALL, ERROR.
  - IDLE:
    - clkp_q==0 and if_q=1 -> RISE.
    - clkp_q==0 and if_q=0 -> stay.
    - Any nonzero code -> ERROR.
  - RISE:
    - k==level -> hold.
    - k==level+1 -> level<=k, pulse stage_en[k-1]. If k==PHASES -> TOP.
    - Anything else -> ERROR.
  - TOP:
    - k==PHASES -> hold.
    - k==PHASES-1 -> FALL, dir<=0, level<=PHASES-1, pulse stage_rel[PHASES-1].
    - Anything else -> ERROR.
  - FALL:
    - k==level -> hold.
    - k==level-1 -> level<=k, pulse stage_rel[k]. If k==0 -> pulse cycle_done, cycle_count+1, IDLE.
    - Anything else -> ERROR.
  - ERROR:
    - level<=0, dir<=0, no strobes.
    - Leave to RISE only when clkp_q==0 and if_q=1 (resync at instruction boundary).
- Invalid (non-thermometer) code in any state -> ERROR.
- dir: 1 from the IDLE->RISE transition through TOP; 0 otherwise.
- err: set on entry to ERROR. Cleared by err_clr only when no new error is detected the same cycle; set wins.
- stage_en and stage_rel are never both nonzero. At most one bit of either is set per cycle.
- cycle_count is never reset by errors, only by reset_n. Wrap from 2^CNT_W-1 to 0 with no flag.
- Reset asserted mid-sequence: immediate return to reset values. After release, the decoder waits in IDLE for the next all-low + instFlag.

Decomposition:
- Package bennett_pkg holds:
  - phase_state_e enum (IDLE, RISE, TOP, FALL, ERROR).
  - function is_thermo(vec), returning valid and k.
  - shared PHASES default, reused by the generator.
- One sub-module, bennett_thermo_check: combinational popcount + thermometer validity. Keeps the FSM file small.

Test Plan (PHASES=4, CNT_W=16):
1. Drive the generator sequence with ramps resolved high: 0000+if, 0000, 0001, 0011, 0111, 1111, 0111, 0011, 0001, 0000. Expect:
   - stage_en pulses 0001, 0010, 0100, 1000;
   - stage_rel pulses 1000, 0100, 0010, 0001;
   - cycle_done once, cycle_count=1, err=0.
2. Same sequence with every ramp step held one extra cycle (ramp phase reads as its old level) -> identical strobe order, no error.
3. Inject 0101 during RISE -> err=1, locked=0, no further strobes until 0000+if. Then a clean cycle completes with cycle_count incremented and err still 1. Pulse err_clr -> err=0.
4. Jump 0001->0111 (skip a step) -> ERROR. Same-cycle err_clr with a new error -> err stays 1.
5. Assert reset_n=0 while level=3 in FALL -> all outputs 0 immediately. Release with clkp=0011 -> stay IDLE, no error. Resync on the next 0000+if.
6. Preload by running 65535 cycles (or force) then one more -> cycle_count wraps to 0, cycle_done still pulses.
